// File: rtl/rfphoenix_icmiss_ctrl_pkg.sv
// Shared types and constants for the instruction-cache miss/maintenance controller.
package rfphoenix_icmiss_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    BEAT,
    TAG,
    INV
  } icmiss_state_t;

  localparam int ICLINE_BEATS = 4;

  // Upper tag bits of an invalidated entry: all ones lands in uncached I/O space.
  localparam logic [63:0] IC_INV_TAG_HI = '1;

endpackage

// File: rtl/rfphoenix_icmiss_ctrl_victim.sv
// Round-robin victim-way selector; interface kept small so an LRU can drop in later.
module rfphoenix_icmiss_ctrl_victim (
  input  logic       clk,
  input  logic       rst,
  input  logic       advance,
  output logic [1:0] way
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      way <= 2'd0;
    end else if (advance) begin
      way <= way + 2'd1;
    end
  end

endmodule

// File: rtl/rfphoenix_icmiss_ctrl.sv
// I$ miss refill and full-invalidate sequencer; sole writer of the I$ tag store.
module rfphoenix_icmiss_ctrl
  import rfphoenix_icmiss_ctrl_pkg::*;
#(
  parameter int AWID  = 32,
  parameter int LINES = 128,
  parameter int WAYS  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_v,
  input  logic [AWID-1:0] ip,
  input  logic [3:0]      hit,
  input  logic            invall,
  output logic            busy,
  output logic            done,
  output logic            mreq,
  output logic [AWID-1:0] madr,
  input  logic            mack,
  input  logic            mdat_v,
  input  logic [127:0]    mdat,
  output logic            dwr,
  output logic [1:0]      dway,
  output logic [6:0]      dline,
  output logic [1:0]      dbeat,
  output logic [127:0]    ddat,
  output logic            twr,
  output logic [AWID-1:0] tipo,
  output logic [1:0]      tway
);

  localparam int WALK_W = $clog2(LINES * WAYS);
  localparam logic [1:0] LAST_BEAT = 2'(ICLINE_BEATS - 1);

  icmiss_state_t     state;
  logic [AWID-1:0]   miss;
  logic [1:0]        victim;
  logic [1:0]        rr;
  logic [1:0]        beat;
  logic [WALK_W-1:0] w;
  logic [WALK_W-1:0] w_next;
  logic              pend;

  function automatic logic [AWID-1:0] inv_addr(input logic [6:0] idx);
    return {IC_INV_TAG_HI[AWID-14:0], idx, 6'b0};
  endfunction

  assign w_next = w + 1'b1;

  rfphoenix_icmiss_ctrl_victim u_victim (
    .clk     (clk),
    .rst     (rst),
    .advance (state == TAG),
    .way     (rr)
  );

  // Data-array writes follow the memory beats directly; the tag waits for the last one.
  assign dwr   = (state == BEAT) && mdat_v;
  assign dway  = victim;
  assign dline = miss[12:6];
  assign dbeat = beat;
  assign ddat  = dwr ? mdat : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      miss   <= '0;
      victim <= 2'd0;
      beat   <= 2'd0;
      w      <= '0;
      pend   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      mreq   <= 1'b0;
      madr   <= '0;
      twr    <= 1'b0;
      tipo   <= '0;
      tway   <= 2'd0;
    end else begin
      done <= 1'b0;
      if (invall && state != IDLE) pend <= 1'b1;
      case (state)
        IDLE: begin
          if (invall || pend) begin
            state <= INV;
            pend  <= 1'b0;
            w     <= '0;
            busy  <= 1'b1;
            twr   <= 1'b1;
            tway  <= 2'd0;
            tipo  <= inv_addr(7'd0);
          end else if (fetch_v && hit == 4'd0) begin
            state  <= REQ;
            miss   <= ip;
            victim <= rr;
            busy   <= 1'b1;
            mreq   <= 1'b1;
            madr   <= {ip[AWID-1:6], 6'b0};
          end
        end
        REQ: begin
          if (mack) begin
            state <= BEAT;
            beat  <= 2'd0;
            mreq  <= 1'b0;
          end
        end
        BEAT: begin
          if (mdat_v) begin
            beat <= beat + 2'd1;
            if (beat == LAST_BEAT) begin
              state <= TAG;
              twr   <= 1'b1;
              tipo  <= miss;
              tway  <= victim;
              done  <= 1'b1;
            end
          end
        end
        TAG: begin
          state <= IDLE;
          twr   <= 1'b0;
          busy  <= 1'b0;
        end
        INV: begin
          // Outputs always show entry w; the last entry's cycle carries done.
          if (w == '1) begin
            state <= IDLE;
            twr   <= 1'b0;
            busy  <= 1'b0;
          end else begin
            w    <= w_next;
            tway <= w_next[WALK_W-1 -: 2];
            tipo <= inv_addr(w_next[6:0]);
            done <= (w_next == '1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rfphoenix_icmiss_ctrl.sv
// Scoreboard bench: driver pushes expected memory/data/tag transactions, monitor pops and compares.
module tb_rfphoenix_icmiss_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         fetch_v = 1'b0;
  logic [31:0]  ip = '0;
  logic [3:0]   hit = '0;
  logic         invall = 1'b0;
  logic         busy, done, mreq;
  logic [31:0]  madr;
  logic         mack = 1'b0;
  logic         mdat_v = 1'b0;
  logic [127:0] mdat = '0;
  logic         dwr;
  logic [1:0]   dway;
  logic [6:0]   dline;
  logic [1:0]   dbeat;
  logic [127:0] ddat;
  logic         twr;
  logic [31:0]  tipo;
  logic [1:0]   tway;

  rfphoenix_icmiss_ctrl dut (
    .clk(clk), .rst(rst), .fetch_v(fetch_v), .ip(ip), .hit(hit), .invall(invall),
    .busy(busy), .done(done), .mreq(mreq), .madr(madr), .mack(mack),
    .mdat_v(mdat_v), .mdat(mdat), .dwr(dwr), .dway(dway), .dline(dline),
    .dbeat(dbeat), .ddat(ddat), .twr(twr), .tipo(tipo), .tway(tway)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]   way;
    logic [6:0]   line;
    logic [1:0]   beat;
    logic [127:0] data;
  } dwr_t;

  typedef struct packed {
    logic        done;
    logic [1:0]  way;
    logic [31:0] addr;
  } twr_t;

  dwr_t        dq[$];
  twr_t        tq[$];
  logic [31:0] mq[$];

  int vec  = 0;
  int errs = 0;
  int rr_m = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Monitor: every DUT output transaction must match the next expected one.
  logic prev_mreq = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      prev_mreq = 1'b0;
    end else begin
      if (mreq && !prev_mreq) begin
        if (mq.size() == 0) chk("mreq_spurious", mreq, 0);
        else chk("madr", madr, mq.pop_front());
      end
      if (dwr) begin
        if (dq.size() == 0) chk("dwr_spurious", dwr, 0);
        else chk("dwr", {dway, dline, dbeat, ddat}, dq.pop_front());
      end
      if (twr) begin
        if (tq.size() == 0) chk("twr_spurious", twr, 0);
        else chk("twr", {done, tway, tipo}, tq.pop_front());
      end else if (done) begin
        chk("done_without_twr", done, 0);
      end
      prev_mreq = mreq;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while (busy && n < lim) begin
      step();
      n++;
    end
    chk("idle_timeout", busy, 0);
  endtask

  task automatic push_inv();
    for (int i = 0; i < 512; i++) begin
      twr_t t;
      t.done = (i == 511);
      t.way  = 2'(i / 128);
      t.addr = 32'hFFFF_E000 + 32'((i % 128) * 64);
      tq.push_back(t);
    end
  endtask

  task automatic chk_outs_zero(input string nm);
    chk(nm, {busy, done, mreq, madr, dwr, dway, dline, dbeat, ddat, twr, tipo, tway}, 0);
  endtask

  // gap_before: beat index preceded by a 2-cycle mdat_v gap (>=4: none).
  // inv_beat: beat during which invall pulses (<0: none). rst_beat: beat hit by reset (<0: none).
  task automatic refill(input logic [31:0] a, input int ack_dly, input int gap_before,
                        input int inv_beat, input int rst_beat);
    logic [127:0] d[4];
    for (int b = 0; b < 4; b++) d[b] = {$urandom, $urandom, $urandom, $urandom};
    fetch_v = 1'b1;
    ip      = a;
    hit     = 4'd0;
    mq.push_back({a[31:6], 6'b0});
    step();
    fetch_v = 1'b0;
    ip      = $urandom;
    chk("mreq_n1", mreq, 1);
    chk("busy_n1", busy, 1);
    for (int i = 0; i < ack_dly; i++) begin
      fetch_v = 1'($urandom % 2);
      ip      = $urandom;
      mdat_v  = 1'($urandom % 2);
      mdat    = {$urandom, $urandom, $urandom, $urandom};
      step();
      chk("mreq_held", mreq, 1);
    end
    fetch_v = 1'b0;
    mdat_v  = 1'b0;
    mack    = 1'b1;
    step();
    mack = 1'b0;
    chk("mreq_drop", mreq, 0);
    for (int b = 0; b < 4; b++) begin
      if (b == gap_before) begin
        repeat (2) begin
          mdat_v  = 1'b0;
          fetch_v = 1'($urandom % 2);
          ip      = $urandom;
          step();
        end
        fetch_v = 1'b0;
      end
      if (b == rst_beat) begin
        mdat_v = 1'b1;
        mdat   = d[b];
        #1 rst = 1'b0;
        #1;
        chk_outs_zero("rst_mid_outs");
        mdat_v = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        rr_m = 0;
        return;
      end
      if (b == inv_beat) invall = 1'b1;
      dq.push_back({2'(rr_m), a[12:6], 2'(b), d[b]});
      mdat_v = 1'b1;
      mdat   = d[b];
      step();
      invall = 1'b0;
    end
    mdat_v = 1'b0;
    tq.push_back({1'b1, 2'(rr_m), a});
    if (inv_beat >= 0) push_inv();
    rr_m = (rr_m + 1) % 4;
    chk("twr_tag_cycle", twr, 1);
    chk("done_tag_cycle", done, 1);
    step();
    chk("busy_after_done", busy, 0);
    if (inv_beat >= 0) begin
      step();
      chk("inv_after_refill", busy, 1);
      wait_idle(600);
    end
  endtask

  task automatic inv_idle();
    int n = 0;
    invall = 1'b1;
    push_inv();
    step();
    invall = 1'b0;
    chk("inv_busy", busy, 1);
    while (busy && n < 600) begin
      if (twr) n++;
      step();
    end
    chk("inv_len", n, 512);
    chk("inv_idle_busy", busy, 0);
  endtask

  task automatic hits(input int n);
    for (int i = 0; i < n; i++) begin
      fetch_v = 1'b1;
      ip      = $urandom;
      hit     = 4'(1 << ($urandom % 4));
      step();
      chk("hit_no_busy", busy, 0);
      chk("hit_no_mreq", mreq, 0);
    end
    fetch_v = 1'b0;
    hit     = 4'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_outs_zero("reset_outs");
    rst = 1'b1;
    step();
    chk_outs_zero("post_reset_outs");

    refill(32'h0000_1240, 0, 4, -1, -1);
    for (int i = 0; i < 4; i++) refill(32'h0000_2000 + 32'(i * 64), 0, 4, -1, -1);
    refill(32'h8000_0A80, 5, 2, -1, -1);
    hits(5);
    inv_idle();
    refill($urandom, 1, 4, 1, -1);
    refill($urandom, 0, 4, -1, 2);
    hits(2);
    refill($urandom, 0, 4, -1, -1);
    for (int i = 0; i < 20; i++) begin
      refill($urandom, int'($urandom % 4), int'($urandom % 5), -1, -1);
      if ($urandom % 2) hits(1);
    end

    repeat (4) step();
    chk("dq_empty", dq.size(), 0);
    chk("tq_empty", tq.size(), 0);
    chk("mq_empty", mq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
